// File: rtl/axis_spi_master.sv
// SPI bus master: one full-duplex DATA_WIDTH-bit transfer per accepted s_axis word,
// MSB first, with the word received on MISO returned on m_axis. All outputs registered.
//
// state | meaning
// IDLE  | CS high, waiting for an s_axis word (only while no rx word is pending)
// SETUP | CS low, MSB on MOSI, first SCLK half-period before edge 1
// SHIFT | SCLK edges 1..2W, MISO sampled / MOSI advanced per CPHA
// HOLD  | one half-period after the last edge before CS rises
// GAP   | CS high for CLK_DIV cycles before the next word may start
module axis_spi_master #(
  parameter int SPI_MODE   = 1,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  spi_clk_o,
  output logic                  spi_cs_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   CW   = $clog2(CLK_DIV);
  localparam int   EW   = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH);
  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [DATA_WIDTH-2:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  s_ready_q, s_ready_d;

  logic          tc;
  logic [EW-1:0] edge_nxt;
  logic          lead;
  logic          smp;
  logic          adv;

  assign tc       = (cnt_q == '0);
  assign edge_nxt = edge_q + 1'b1;
  assign lead     = edge_nxt[0];
  assign smp      = lead ^ CPHA;
  // The first bit is already on MOSI from CS fall, so neither mode advances before it is sampled.
  assign adv      = CPHA ? (lead && (edge_nxt != EDGE_ONE)) : (!lead && (edge_nxt != EDGE_LAST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid && s_ready_q) begin
          state_d = S_SETUP;
          cnt_d   = DIV_LAST;
          edge_d  = '0;
          tx_d    = s_axis_tdata[DATA_WIDTH-2:0];
          rx_d    = '0;
          cs_d    = 1'b0;
          mosi_d  = s_axis_tdata[DATA_WIDTH-1];
        end
      end
      S_SETUP, S_SHIFT: begin
        if (tc) begin
          cnt_d  = DIV_LAST;
          edge_d = edge_nxt;
          sclk_d = ~sclk_q;
          if (smp) rx_d = {rx_q[DATA_WIDTH-2:0], spi_miso_i};
          if (adv) begin
            mosi_d = tx_q[DATA_WIDTH-2];
            tx_d   = tx_q << 1;
          end
          state_d = (edge_nxt == EDGE_LAST) ? S_HOLD : S_SHIFT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (tc) begin
          cnt_d     = DIV_LAST;
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          m_data_d  = rx_q;
          m_valid_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (tc) begin
          state_d = S_IDLE;
          edge_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered ready, computed from next state so it matches the state it is presented with.
    s_ready_d = (state_d == S_IDLE) && !m_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= CPOL;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign spi_clk_o     = sclk_q;
  assign spi_cs_o      = cs_q;
  assign spi_mosi_o    = mosi_q;
  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;

endmodule
